// File: rtl/fpall_issue_ctrl_pkg.sv
// Shared types for the FPALL issue controller and its FPU-facing payload.
//   fp_fmt_e  : operand format (FP16 = bf16x2 packed lanes)
//   fp_op_e   : FPU operation
//   fpu_req_t : registered operand bundle presented to the shared FPU
package fpall_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    FP32    = 2'd0,
    FP16    = 2'd1,
    FP16ALT = 2'd2,
    FP8     = 2'd3
  } fp_fmt_e;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_MUL    = 2'd2,
    OP_MINMAX = 2'd3
  } fp_op_e;

  typedef struct packed {
    fp_fmt_e     fmt;
    fp_op_e      op;
    logic [31:0] x;
    logic [31:0] y;
  } fpu_req_t;

endpackage

// File: rtl/fpall_issue_ctrl.sv
// Issue/retire controller for the shared FPU: registers each accepted request
// onto the FPU inputs, follows it through the FPU's fixed latency with a tag
// token, and captures the result into an in-order response FIFO.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; req_fmt/op/x/y/tag payload
//   fpu_fmt/opcode/x/y            registered FPU operands (held between issues)
//   fpu_r                         FPU result, valid LAT edges after operands
//   rsp_valid/rsp_ready           response handshake; rsp_r/rsp_tag head entry
//   inflight                      ops issued but not yet captured
// LAT must be >= 1; DEPTH >= 1.
module fpall_issue_ctrl
  import fpall_issue_ctrl_pkg::*;
#(
  parameter int unsigned LAT       = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_W     = 4,
  parameter bit          PIPELINED = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  fp_fmt_e                    req_fmt,
  input  fp_op_e                     req_op,
  input  logic [31:0]                req_x,
  input  logic [31:0]                req_y,
  input  logic [TAG_W-1:0]           req_tag,
  output fp_fmt_e                    fpu_fmt,
  output fp_op_e                     fpu_opcode,
  output logic [31:0]                fpu_x,
  output logic [31:0]                fpu_y,
  input  logic [31:0]                fpu_r,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_r,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic [$clog2(DEPTH+1)-1:0] inflight
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned STAGES = LAT + 1;
  localparam int unsigned DATA_W = 32;

  fpu_req_t                      fpu_q, fpu_d;
  logic [STAGES-1:0]             tok_v_q, tok_v_d;
  logic [STAGES-1:0][TAG_W-1:0]  tok_tag_q, tok_tag_d;
  logic [DATA_W-1:0]             mem_r   [DEPTH];
  logic [TAG_W-1:0]              mem_tag [DEPTH];
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d, inflight_q, inflight_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]             rsp_r_q, rsp_r_d;
  logic [TAG_W-1:0]              rsp_tag_q, rsp_tag_d;
  logic                          credit_q, credit_d;
  logic                          accept, capture, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes; the token leaving the last stage marks fpu_r as this op's result.
  assign accept    = req_valid & req_ready;
  assign capture   = tok_v_q[STAGES-1];
  assign pop       = rsp_valid_q & rsp_ready;
  assign req_ready = ~rst & credit_q;

  always_comb begin
    fpu_d       = fpu_q;
    tok_v_d     = {tok_v_q[STAGES-2:0], accept};
    tok_tag_d   = {tok_tag_q[STAGES-2:0], req_tag};
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(capture) - CNT_W'(pop);
    inflight_d  = inflight_q + CNT_W'(accept) - CNT_W'(capture);
    rsp_valid_d = 1'b0;
    rsp_r_d     = mem_r[rd_ptr_q];
    rsp_tag_d   = mem_tag[rd_ptr_q];
    credit_d    = 1'b0;

    if (accept) begin
      fpu_d = '{fmt: req_fmt, op: req_op, x: req_x, y: req_y};
    end
    if (capture) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // Registered head: take the entry being written this edge if it lands on the new head.
    rsp_valid_d = (count_d != '0);
    if (capture && (wr_ptr_q == rd_ptr_d)) begin
      rsp_r_d   = fpu_r;
      rsp_tag_d = tok_tag_q[STAGES-1];
    end else begin
      rsp_r_d   = mem_r[rd_ptr_d];
      rsp_tag_d = mem_tag[rd_ptr_d];
    end

    // Queued plus in-flight never exceeds DEPTH, so every capture finds a free slot.
    credit_d = (({1'b0, count_d} + {1'b0, inflight_d}) < SUM_W'(DEPTH)) &&
               (PIPELINED || (inflight_d == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_q       <= '{fmt: FP16, op: OP_ADD, x: '0, y: '0};
      tok_v_q     <= '0;
      tok_tag_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_r_q     <= '0;
      rsp_tag_q   <= '0;
      credit_q    <= 1'b1;
    end else begin
      fpu_q       <= fpu_d;
      tok_v_q     <= tok_v_d;
      tok_tag_q   <= tok_tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_r_q     <= rsp_r_d;
      rsp_tag_q   <= rsp_tag_d;
      credit_q    <= credit_d;
    end
  end

  // Result storage; contents are meaningless unless covered by count_q.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      mem_r[wr_ptr_q]   <= fpu_r;
      mem_tag[wr_ptr_q] <= tok_tag_q[STAGES-1];
    end
  end

  assign fpu_fmt    = fpu_q.fmt;
  assign fpu_opcode = fpu_q.op;
  assign fpu_x      = fpu_q.x;
  assign fpu_y      = fpu_q.y;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_r      = rsp_r_q;
  assign rsp_tag    = rsp_tag_q;
  assign inflight   = inflight_q;

endmodule

// File: tb/tb_fpall_issue_ctrl.sv
// Bench for fpall_issue_ctrl: a pipelined and a non-pipelined instance share
// one stimulus stream; each has its own LAT=2 FPU model and a transaction-level
// reference (outstanding-op queue with capture times) checked every cycle.
module tb_fpall_issue_ctrl;
  import fpall_issue_ctrl_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int          DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct {
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
    int unsigned      cap;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  fp_fmt_e          req_fmt;
  fp_op_e           req_op;
  logic [31:0]      req_x, req_y;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_ready;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic real bf16_to_real(input logic [15:0] h);
    logic [63:0] b;
    if (h[14:0] == 15'd0) return 0.0;
    b = {h[15], 11'(h[14:7]) + 11'd896, h[6:0], 45'd0};
    return $bitstoreal(b);
  endfunction

  // Round-to-nearest-even of a double back to bf16 (operands kept in the normal range).
  function automatic logic [15:0] real_to_bf16(input real v);
    logic [63:0] b;
    logic [10:0] e;
    logic [14:0] mag;
    b = $realtobits(v);
    if (b[62:0] == 63'd0) return 16'h0000;
    e   = b[62:52] - 11'd896;
    mag = {e[7:0], b[51:45]};
    if (b[44] && ((|b[43:0]) || b[45])) mag = mag + 15'd1;
    return {b[63], mag};
  endfunction

  function automatic logic [31:0] fpu_fn(input fp_fmt_e fmt, input fp_op_e op,
                                         input logic [31:0] x, input logic [31:0] y);
    if (fmt == FP16 && op == OP_ADD)
      return {real_to_bf16(bf16_to_real(x[31:16]) + bf16_to_real(y[31:16])),
              real_to_bf16(bf16_to_real(x[15:0])  + bf16_to_real(y[15:0]))};
    return x ^ {y[15:0], y[31:16]} ^ {28'd0, op, fmt};
  endfunction

  function automatic logic [15:0] rand_bf16();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 7'($urandom_range(0, 127))};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit PIPE = (g == 1);

    logic             req_ready, rsp_valid;
    logic [31:0]      rsp_r, fpu_x, fpu_y, fpu_r, fpu_s1;
    logic [TAG_W-1:0] rsp_tag;
    logic [CNT_W-1:0] inflight;
    fp_fmt_e          fpu_fmt;
    fp_op_e           fpu_opcode;

    fpall_issue_ctrl #(
      .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W), .PIPELINED(PIPE)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_fmt(req_fmt), .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
      .fpu_fmt(fpu_fmt), .fpu_opcode(fpu_opcode), .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_r(fpu_r),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r), .rsp_tag(rsp_tag),
      .inflight(inflight)
    );

    // Shared FPU: result valid two edges after its operands change.
    always @(posedge clk) begin
      fpu_s1 <= fpu_fn(fpu_fmt, fpu_opcode, fpu_x, fpu_y);
      fpu_r  <= fpu_s1;
    end

    // Reference: q holds every accepted, not yet popped op with the edge it is captured on.
    exp_t        q[$];
    int unsigned k = 0;
    bit          started = 1'b0;
    logic [31:0] last_x, last_y;
    fp_fmt_e     last_fmt;
    fp_op_e      last_op;

    initial begin
      int  infl;
      bit  vexp, rexp, acc, pop;
      forever begin
        @(negedge clk);
        infl = 0;
        foreach (q[i]) if (q[i].cap > k) infl++;
        vexp = (q.size() > 0) && (q[0].cap <= k);
        rexp = !rst && (q.size() < DEPTH) && (PIPE || infl == 0);
        if (started) begin
          check($sformatf("p%0d.req_ready", g), 32'(req_ready), 32'(rexp));
          check($sformatf("p%0d.rsp_valid", g), 32'(rsp_valid), 32'(vexp));
          check($sformatf("p%0d.inflight", g), 32'(inflight), 32'(infl));
          check($sformatf("p%0d.fpu_x", g), fpu_x, last_x);
          check($sformatf("p%0d.fpu_y", g), fpu_y, last_y);
          check($sformatf("p%0d.fpu_fmt_op", g), 32'({fpu_fmt, fpu_opcode}), 32'({last_fmt, last_op}));
          if (vexp) begin
            check($sformatf("p%0d.rsp_r", g), rsp_r, q[0].r);
            check($sformatf("p%0d.rsp_tag", g), 32'(rsp_tag), 32'(q[0].tag));
          end
        end
        acc = req_valid && rexp;
        pop = !rst && rsp_ready && vexp;
        k++;
        if (rst) begin
          q.delete();
          started  = 1'b1;
          last_x   = '0;
          last_y   = '0;
          last_fmt = FP16;
          last_op  = OP_ADD;
        end else begin
          if (pop) void'(q.pop_front());
          if (acc) begin
            q.push_back('{r: fpu_fn(req_fmt, req_op, req_x, req_y), tag: req_tag, cap: k + LAT + 1});
            last_x   = req_x;
            last_y   = req_y;
            last_fmt = req_fmt;
            last_op  = req_op;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input bit force_add);
    req_fmt = force_add ? FP16 : (($urandom_range(0, 3) == 0) ? fp_fmt_e'(2'($urandom_range(0, 3))) : FP16);
    req_op  = force_add ? OP_ADD : (($urandom_range(0, 3) == 0) ? fp_op_e'(2'($urandom_range(0, 3))) : OP_ADD);
    req_x   = {rand_bf16(), rand_bf16()};
    req_y   = {rand_bf16(), rand_bf16()};
    req_tag = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
  endtask

  initial begin
    int lat;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_fmt = FP16; req_op = OP_ADD; req_x = '0; req_y = '0; req_tag = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single bf16x2 add: 1.0+1.0 | 2.0+1.0
    req_valid = 1'b1; req_fmt = FP16; req_op = OP_ADD;
    req_x = 32'h3F804000; req_y = 32'h3F803F80; req_tag = 4'd5;
    step();
    req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (g_dut[1].rsp_valid) begin
        lat = i;
        break;
      end
    end
    check("single.latency", 32'(lat), 32'd3);
    check("single.rsp_r", g_dut[1].rsp_r, 32'h40004040);
    check("single.rsp_tag", 32'(g_dut[1].rsp_tag), 32'd5);
    step();
    check("single.valid_1cyc", 32'(g_dut[1].rsp_valid), 32'd0);
    repeat (6) step();

    // Back-to-back accepts, tags 0..3
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      rand_req(1'b1);
      req_tag = TAG_W'(i);
      step();
    end
    req_valid = 1'b0;
    repeat (10) step();

    // Backpressure: fill to DEPTH, then release
    rsp_ready = 1'b0; req_valid = 1'b1;
    repeat (10) begin rand_req(1'b0); step(); end
    rsp_ready = 1'b1;
    repeat (12) begin rand_req(1'b0); step(); end
    req_valid = 1'b0;
    repeat (20) step();

    // Reset with ops in flight and one queued
    rsp_ready = 1'b0; req_valid = 1'b1;
    repeat (3) begin rand_req(1'b1); step(); end
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("reset.inflight", 32'(g_dut[1].inflight), 32'd0);
    check("reset.rsp_valid", 32'(g_dut[1].rsp_valid), 32'd0);
    rsp_ready = 1'b1; req_valid = 1'b1;
    rand_req(1'b1);
    req_tag = 4'd9;
    step();
    req_valid = 1'b0;
    repeat (10) step();

    // Pop coinciding with a capture while credit is exhausted
    rsp_ready = 1'b0; req_valid = 1'b1;
    repeat (4) begin rand_req(1'b1); step(); end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) step();

    // Random traffic with occasional reset
    repeat (800) begin
      req_valid = ($urandom_range(0, 9) < 7);
      rsp_ready = ($urandom_range(0, 9) < 6);
      rst       = ($urandom_range(0, 99) == 0);
      rand_req(1'b0);
      step();
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
